bus_grant_ctl: RTL and testbench

//  Sequential owner of the shared memory bus, directly downstream of the 4-way fixed-priority select.

---
 rtl/bus_arb_pkg.sv | 39 +++
 rtl/bus_grant_wdog.sv | 48 ++++
 rtl/bus_grant_ctl.sv | 154 +++++++++++++++
 tb/tb_bus_grant_ctl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// bus_arb_pkg
//   Shared definitions for the bus grant controller: FSM state encoding,
//   master count, and helpers for interpreting one-hot grant vectors.
package bus_arb_pkg;

  localparam int NUM_MASTERS = 4;
  localparam int ID_W        = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_BUSY    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  // Binary index of a one-hot vector (OR of the indices of set bits, so a
  // one-hot input yields exactly its index; zero input yields 0).
  function automatic logic [ID_W-1:0] onehot_encode(input logic [NUM_MASTERS-1:0] oh);
    logic [ID_W-1:0] id;
    id = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (oh[i]) begin
        id = id | ID_W'(i);
      end
    end
    return id;
  endfunction

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [NUM_MASTERS-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      n = n + 32'(v[i]);
    end
    return (n == 1);
  endfunction

endpackage

// File: rtl/bus_grant_wdog.sv
// bus_grant_wdog
//   Saturating cycle counter guarding a bus transaction.
//   Ports:
//     clk    in  clock, rising edge
//     rst    in  synchronous active-high reset (counter -> 0)
//     clr    in  clear counter (asserted on the cycle before BUSY is entered)
//     en     in  count this cycle (asserted during BUSY)
//     expire out high in the LIMIT-th enabled cycle since the last clear
//   Only instantiated when BUS_GRANT_TIMEOUT_EN is defined.
module bus_grant_wdog #(
  parameter int LIMIT = 255,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds the number of BUSY cycles already completed, so the cycle in
  // which it equals LIMIT-1 is the LIMIT-th BUSY cycle.
  assign expire = en && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/bus_grant_ctl.sv
// bus_grant_ctl
//   Owns the shared memory bus downstream of the 4-way fixed-priority select.
//   Enables the select while idle, locks the granted master for one memory
//   transaction, and releases the bus on mem_done (plus one dead cycle).
//   Ports:
//     clk          in   clock, rising edge
//     rst          in   synchronous active-high reset
//     g[3:0]       in   one-hot grants from the select
//     R            in   any-request from the select
//     G            out  enable to the select (high in IDLE)
//     mem_done     in   end of current memory transaction
//     mem_start    out  1-cycle pulse at transaction start
//     ack[3:0]     out  1-cycle one-hot pulse to the granted master
//     owner[3:0]   out  one-hot current owner
//     owner_id[1:0] out binary owner index, 0 when no owner
//     busy         out  bus owned (GRANT or BUSY)
//     timeout_err  out  sticky forced-release flag
//   Configuration macro: BUS_GRANT_TIMEOUT_EN enables the BUSY watchdog.
//   All outputs are registered from the next-state values.
module bus_grant_ctl
  import bus_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] g,
  input  logic                   R,
  output logic                   G,
  input  logic                   mem_done,
  output logic                   mem_start,
  output logic [NUM_MASTERS-1:0] ack,
  output logic [NUM_MASTERS-1:0] owner,
  output logic [ID_W-1:0]        owner_id,
  output logic                   busy,
  output logic                   timeout_err
);

  state_e                 state_q, state_d;
  logic [NUM_MASTERS-1:0] owner_q, owner_d;
  logic [ID_W-1:0]        owner_id_q, owner_id_d;
  logic [NUM_MASTERS-1:0] ack_q, ack_d;
  logic                   mem_start_q, mem_start_d;
  logic                   busy_q, busy_d;
  logic                   g_en_q, g_en_d;
  logic                   terr_q, terr_d;

`ifdef BUS_GRANT_TIMEOUT_EN
  logic wdog_expire;

  bus_grant_wdog #(
    .LIMIT (TIMEOUT_CYCLES),
    .CNT_W (CNT_W)
  ) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == ST_GRANT),
    .en     (state_q == ST_BUSY),
    .expire (wdog_expire)
  );
`else
  // The watchdog parameters stay on the interface so both builds can be
  // instantiated identically; here they only feed this sink.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES < (1 << CNT_W));
`endif

  // Next-state and latched owner/error bookkeeping.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    owner_id_d = owner_id_q;
    terr_d     = terr_q;
    case (state_q)
      ST_IDLE: begin
        // Non-one-hot grants are a select protocol violation: ignore them.
        if (R && is_onehot(g)) begin
          state_d    = ST_GRANT;
          owner_d    = g;
          owner_id_d = onehot_encode(g);
        end
      end
      ST_GRANT: begin
        // mem_done here belongs to no transaction of ours and is dropped.
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (mem_done) begin
          state_d    = ST_RELEASE;
          owner_d    = '0;
          owner_id_d = '0;
`ifdef BUS_GRANT_TIMEOUT_EN
        end else if (wdog_expire) begin
          state_d    = ST_RELEASE;
          owner_d    = '0;
          owner_id_d = '0;
          terr_d     = 1'b1;
`endif
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d    = ST_IDLE;
        owner_d    = '0;
        owner_id_d = '0;
      end
    endcase
  end

  // Output decode from the next state so every output is a flop.
  always_comb begin
    g_en_d      = (state_d == ST_IDLE);
    mem_start_d = (state_d == ST_GRANT);
    busy_d      = (state_d == ST_GRANT) || (state_d == ST_BUSY);
  end

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_ack
    assign ack_d[gi] = (state_d == ST_GRANT) && owner_d[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      owner_id_q  <= '0;
      ack_q       <= '0;
      mem_start_q <= 1'b0;
      busy_q      <= 1'b0;
      g_en_q      <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      owner_id_q  <= owner_id_d;
      ack_q       <= ack_d;
      mem_start_q <= mem_start_d;
      busy_q      <= busy_d;
      g_en_q      <= g_en_d;
      terr_q      <= terr_d;
    end
  end

  assign G           = g_en_q;
  assign mem_start   = mem_start_q;
  assign ack         = ack_q;
  assign owner       = owner_q;
  assign owner_id    = owner_id_q;
  assign busy        = busy_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_bus_grant_ctl.sv
// tb_bus_grant_ctl
//   Drives bus_grant_ctl with directed scenarios followed by randomized
//   select traffic, comparing every output each cycle against a
//   transaction-level model (owner index + age since grant).
module tb_bus_grant_ctl;

  localparam int TO = 8;
`ifdef BUS_GRANT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       R = 1'b0;
  logic       mem_done = 1'b0;
  logic [3:0] g = 4'b0000;
  logic       G, mem_start, busy, timeout_err;
  logic [3:0] ack, owner;
  logic [1:0] owner_id;

  int n_checks = 0;
  int n_errors = 0;

  // Model: which master owns the bus (-1 = none), how many cycles since its
  // ack (0 = ack cycle), whether this is the dead cycle after a release,
  // whether reset was sampled on the previous edge, and the sticky error.
  int m_owner     = -1;
  int m_age       = 0;
  bit m_rel       = 1'b0;
  bit m_rst_prev  = 1'b1;
  bit m_terr      = 1'b0;
  int cyc         = 0;
  int last_done   = -100;

  always #5 clk = ~clk;

  bus_grant_ctl #(
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .g           (g),
    .R           (R),
    .G           (G),
    .mem_done    (mem_done),
    .mem_start   (mem_start),
    .ack         (ack),
    .owner       (owner),
    .owner_id    (owner_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    cyc++;
    if (rst) begin
      m_owner    = -1;
      m_age      = 0;
      m_rel      = 1'b0;
      m_terr     = 1'b0;
      m_rst_prev = 1'b1;
      last_done  = -100;
    end else begin
      m_rst_prev = 1'b0;
      if (m_rel) begin
        m_rel = 1'b0;
      end else if (m_owner < 0) begin
        if (R && $countones(g) == 1) begin
          for (int i = 0; i < 4; i++) if (g[i]) m_owner = i;
          m_age = 0;
        end
      end else if (m_age == 0) begin
        m_age = 1;
      end else if (mem_done) begin
        m_owner   = -1;
        m_rel     = 1'b1;
        last_done = cyc - 1;
      end else if (TO_EN && m_age >= TO) begin
        m_owner = -1;
        m_rel   = 1'b1;
        m_terr  = 1'b1;
      end else begin
        m_age++;
      end
    end
  endtask

  task automatic check_outputs();
    logic [3:0] e_oh;
    logic       e_ack;
    e_oh  = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    e_ack = (m_owner >= 0) && (m_age == 0);
    check_eq("ack",         ack,         e_ack ? e_oh : 4'b0000);
    check_eq("mem_start",   mem_start,   e_ack);
    check_eq("owner",       owner,       e_oh);
    check_eq("owner_id",    owner_id,    (m_owner >= 0) ? m_owner : 0);
    check_eq("busy",        busy,        m_owner >= 0);
    check_eq("G",           G,           (m_owner < 0) && !m_rel && !m_rst_prev);
    check_eq("timeout_err", timeout_err, m_terr);
    if (ack != 4'b0000) begin
      check_eq("ack_spacing", (cyc - last_done) >= 3, 1);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  logic [3:0] req;

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (2) step();
    check_eq("rst_G", G, 0);
    check_eq("rst_owner", owner, 0);

    // 1: grant of master 2 right after reset release
    rst = 1'b0; R = 1'b1; g = 4'b0100;
    step();
    check_eq("t1_ack", ack, 4'b0100);
    check_eq("t1_mem_start", mem_start, 1);
    check_eq("t1_owner_id", owner_id, 2);
    check_eq("t1_G", G, 0);

    // 2: owner drops its request, stray mem_done in GRANT, done in 5th BUSY cycle
    R = 1'b0; g = 4'b0000; mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    repeat (4) step();
    check_eq("t2_busy_hold", busy, 1);
    mem_done = 1'b1;
    step();
    mem_done = 1'b0;
    check_eq("t2_rel_busy", busy, 0);
    check_eq("t2_rel_G", G, 0);
    step();
    check_eq("t2_idle_G", G, 1);

    // 6: non-one-hot grant is ignored
    R = 1'b1; g = 4'b0011;
    step();
    check_eq("t6_ack", ack, 0);
    check_eq("t6_owner", owner, 0);
    step();

    // 3: all masters requesting; select keeps granting master 0
    g = 4'b0001;
    for (int c = 0; c < 40; c++) begin
      mem_done = 1'($urandom_range(0, 1));
      step();
    end
    mem_done = 1'b0;

    // 4: reset in BUSY
    R = 1'b0; g = 4'b0000;
    repeat (3) step();
    R = 1'b1; g = 4'b0010;
    step();
    R = 1'b0; g = 4'b0000;
    step();
    check_eq("t4_busy_before", busy, 1);
    rst = 1'b1;
    step();
    check_eq("t4_ack", ack, 0);
    check_eq("t4_busy", busy, 0);
    check_eq("t4_owner", owner, 0);
    check_eq("t4_G", G, 0);
    rst = 1'b0;
    step();

    // 5: no mem_done ever; timeout build releases after TO busy cycles
    R = 1'b1; g = 4'b1000;
    step();
    R = 1'b0; g = 4'b0000;
    repeat (12) step();
    check_eq("t5_terr", timeout_err, TO_EN);
    check_eq("t5_busy", busy, !TO_EN);
    rst = 1'b1;
    step();
    check_eq("t5_terr_clr", timeout_err, 0);
    rst = 1'b0;

    // Random select traffic with occasional resets and protocol violations
    for (int c = 0; c < 3000; c++) begin
      req      = 4'($urandom_range(0, 15));
      rst      = ($urandom_range(0, 99) == 0);
      R        = |req;
      g        = req & (~req + 4'd1);
      if ($urandom_range(0, 15) == 0) g = 4'($urandom_range(0, 15));
      mem_done = ($urandom_range(0, 5) == 0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
